// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-shot and auto-reload modes, a one-cycle
// expiry tick, a sticky expired flag and a saturating count of missed ticks.
module countdown_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tick,
  output logic             expired,
  output logic [7:0]       missed_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] period;
  logic             mode_periodic;
  logic             load_hs;
  logic             expire;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A zero period would never expire, so it is treated as one cycle.
  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  assign load_ready = reset_n && (state != S_RUN);
  assign load_hs    = load_valid && load_ready;
  // Expiry is suppressed by a same-cycle stop.
  assign expire     = (state == S_RUN) && !stop && (count == ONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      period        <= '0;
      mode_periodic <= 1'b0;
      count         <= '0;
      running       <= 1'b0;
      tick          <= 1'b0;
      expired       <= 1'b0;
      missed_count  <= 8'd0;
    end else begin
      tick <= expire;

      if (load_hs) begin
        period        <= clamp_period(load_value);
        mode_periodic <= periodic;
        count         <= '0;
        state         <= S_ARMED;
      end else begin
        case (state)
          S_ARMED, S_DONE: begin
            if (start && !stop) begin
              count   <= period;
              state   <= S_RUN;
              running <= 1'b1;
            end
          end
          S_RUN: begin
            if (stop) begin
              count   <= '0;
              state   <= S_ARMED;
              running <= 1'b0;
            end else if (expire) begin
              if (mode_periodic) begin
                count <= period;
              end else begin
                count   <= '0;
                state   <= S_DONE;
                running <= 1'b0;
              end
            end else begin
              count <= count - ONE;
            end
          end
          default: ;
        endcase
      end

      // A coinciding ack clears the miss history but not the new expiry.
      if (expire) begin
        expired <= 1'b1;
        if (ack)
          missed_count <= 8'd0;
        else if (expired)
          missed_count <= sat_inc(missed_count);
      end else if (ack) begin
        expired      <= 1'b0;
        missed_count <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus randomized traffic
// compared against a cycle-count based model of the timer.
module tb_countdown_timer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_value = '0;
  logic         periodic = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] count;
  logic         running;
  logic         tick;
  logic         expired;
  logic [7:0]   missed_count;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .periodic(periodic), .start(start), .stop(stop), .ack(ack),
    .count(count), .running(running), .tick(tick), .expired(expired),
    .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  // Model: a running timer is described by its start edge; the remaining
  // count and expiry edges follow from the number of edges since then.
  int cyc = 0;
  bit m_held, m_run, m_periodic, m_tick, m_expired;
  int m_period, m_t0, m_missed;

  function automatic int exp_count();
    if (!m_run) return 0;
    return m_period - ((cyc - m_t0) % m_period);
  endfunction

  task automatic model_edge();
    bit fire;
    bit was_exp;
    int k;
    cyc++;
    fire = 1'b0;
    if (!reset_n) begin
      m_held = 0; m_run = 0; m_periodic = 0; m_tick = 0; m_expired = 0;
      m_period = 0; m_missed = 0;
      return;
    end
    if (m_run) begin
      if (stop) begin
        m_run = 0;
      end else begin
        k = cyc - m_t0;
        if (m_periodic ? (k % m_period == 0) : (k == m_period)) begin
          fire = 1'b1;
          if (!m_periodic) m_run = 0;
        end
      end
    end else if (load_valid) begin
      m_period = (load_value == 0) ? 1 : int'(load_value);
      m_periodic = periodic;
      m_held = 1;
    end else if (start && !stop && m_held) begin
      m_run = 1;
      m_t0 = cyc;
    end
    was_exp = m_expired;
    if (fire) begin
      m_expired = 1;
      if (ack) m_missed = 0;
      else if (was_exp && m_missed < 255) m_missed++;
    end else if (ack) begin
      m_expired = 0;
      m_missed = 0;
    end
    m_tick = fire;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_expired got=%b exp=0", expired); end
    checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL reset_missed got=%0d exp=0", missed_count); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    reset_n = 1'b1;
    #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL release_load_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_oneshot();
    load_valid = 1'b1; load_value = 16'd5; periodic = 1'b0;
    step();
    load_valid = 1'b0;
    checks++; if (count !== '0 || running !== 1'b0) begin errors++; $display("FAIL oneshot_armed count=%0d running=%b exp=0,0", count, running); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      checks++; if (count !== W'(5 - k)) begin errors++; $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, count, 5 - k); end
      checks++; if (tick !== (k == 5)) begin errors++; $display("FAIL oneshot_tick k=%0d got=%b exp=%b", k, tick, k == 5); end
    end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL oneshot_done_running got=%b exp=0", running); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL oneshot_expired got=%b exp=1", expired); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL oneshot_load_ready got=%b exp=1", load_ready); end
    step();
    checks++; if (tick !== 1'b0 || count !== '0) begin errors++; $display("FAIL oneshot_after tick=%b count=%0d exp=0,0", tick, count); end
  endtask

  task automatic test_periodic_missed();
    load_valid = 1'b1; load_value = 16'd3; periodic = 1'b1; ack = 1'b1;
    step();
    load_valid = 1'b0; ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++; if (tick !== (i % 3 == 0)) begin errors++; $display("FAIL periodic_tick i=%0d got=%b exp=%b", i, tick, i % 3 == 0); end
    end
    checks++; if (missed_count !== 8'd3) begin errors++; $display("FAIL periodic_missed got=%0d exp=3", missed_count); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL periodic_expired got=%b exp=1", expired); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if (expired !== 1'b0 || missed_count !== 8'd0) begin errors++; $display("FAIL periodic_ack expired=%b missed=%0d exp=0,0", expired, missed_count); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL periodic_stop running=%b exp=0", running); end
  endtask

  task automatic test_period_one();
    load_valid = 1'b1; load_value = 16'd0; periodic = 1'b1; ack = 1'b1;
    step();
    load_valid = 1'b0; ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (count !== 16'd1 || tick !== 1'b0) begin errors++; $display("FAIL one_start count=%0d tick=%b exp=1,0", count, tick); end
    for (int i = 1; i <= 300; i++) begin
      step();
      checks++; if (tick !== 1'b1 || count !== 16'd1) begin errors++; $display("FAIL one_cycle i=%0d tick=%b count=%0d exp=1,1", i, tick, count); end
    end
    checks++; if (missed_count !== 8'd255) begin errors++; $display("FAIL one_saturate got=%0d exp=255", missed_count); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++; if (expired !== 1'b1 || missed_count !== 8'd0) begin errors++; $display("FAIL one_ack_tick expired=%b missed=%0d exp=1,0", expired, missed_count); end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_stop_at_one();
    load_valid = 1'b1; load_value = 16'd4; periodic = 1'b1; ack = 1'b1;
    step();
    load_valid = 1'b0; ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL stop_pre_count got=%0d exp=1", count); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL stop_tick got=%b exp=0", tick); end
    checks++; if (count !== '0 || running !== 1'b0) begin errors++; $display("FAIL stop_state count=%0d running=%b exp=0,0", count, running); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL stop_load_ready got=%b exp=1", load_ready); end
    step();
    checks++; if (tick !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL stop_late tick=%b expired=%b exp=0,0", tick, expired); end
  endtask

  task automatic test_load_in_run();
    load_valid = 1'b1; load_value = 16'd3; periodic = 1'b0; ack = 1'b1;
    step();
    ack = 1'b0; load_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0; load_valid = 1'b1; load_value = 16'd9;
    #1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL run_load_ready got=%b exp=0", load_ready); end
    step(); step();
    checks++; if (load_ready !== 1'b0 || count !== 16'd1) begin errors++; $display("FAIL run_ignore ready=%b count=%0d exp=0,1", load_ready, count); end
    load_valid = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL run_period_kept got=%0d exp=3", count); end
    step(); step(); step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_done running=%b exp=0", running); end
    load_valid = 1'b1; load_value = 16'd7;
    #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL done_load_ready got=%b exp=1", load_ready); end
    step();
    load_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (count !== 16'd7) begin errors++; $display("FAIL load7_count got=%0d exp=7", count); end
    stop = 1'b1;
    step();
    stop = 1'b0; load_valid = 1'b1; load_value = 16'd2; start = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b0;
    checks++; if (running !== 1'b0 || count !== '0) begin errors++; $display("FAIL load_start running=%b count=%0d exp=0,0", running, count); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL load_start_period got=%0d exp=2", count); end
    step(); step();
  endtask

  task automatic test_reset_mid_run();
    load_valid = 1'b1; load_value = 16'd3; periodic = 1'b0; ack = 1'b1;
    step();
    load_valid = 1'b0; ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL rst_pre_count got=%0d exp=1", count); end
    reset_n = 1'b0;
    step();
    checks++; if (tick !== 1'b0 || count !== '0 || running !== 1'b0) begin errors++; $display("FAIL rst_mid tick=%b count=%0d running=%b exp=0,0,0", tick, count, running); end
    checks++; if (expired !== 1'b0 || missed_count !== 8'd0 || load_ready !== 1'b0) begin errors++; $display("FAIL rst_flags expired=%b missed=%0d ready=%b exp=0,0,0", expired, missed_count, load_ready); end
    reset_n = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (running !== 1'b0 || count !== '0) begin errors++; $display("FAIL rst_start_ignored running=%b count=%0d exp=0,0", running, count); end
    step();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_no_tick got=%b exp=0", tick); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      load_valid = ($urandom_range(0, 9) == 0);
      load_value = W'($urandom_range(0, 6));
      periodic   = $urandom_range(0, 1);
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 19) == 0);
      ack        = ($urandom_range(0, 11) == 0);
      step();
      checks++; if (count !== W'(exp_count())) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, exp_count()); end
      checks++; if (tick !== m_tick) begin errors++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", cyc, tick, m_tick); end
      checks++; if (running !== m_run) begin errors++; $display("FAIL rand_running cyc=%0d got=%b exp=%b", cyc, running, m_run); end
      checks++; if (expired !== m_expired) begin errors++; $display("FAIL rand_expired cyc=%0d got=%b exp=%b", cyc, expired, m_expired); end
      checks++; if (missed_count !== 8'(m_missed)) begin errors++; $display("FAIL rand_missed cyc=%0d got=%0d exp=%0d", cyc, missed_count, m_missed); end
      checks++; if (load_ready !== (reset_n && !m_run)) begin errors++; $display("FAIL rand_load_ready cyc=%0d got=%b exp=%b", cyc, load_ready, reset_n && !m_run); end
    end
    reset_n = 1'b1; load_valid = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_missed();
    test_period_one();
    test_stop_at_one();
    test_load_in_run();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
